// File: rtl/sr_input_cond_pkg.sv
// sr_input_cond_pkg: shared constants for the shift-register input conditioner
package sr_input_cond_pkg;
  localparam int DB_CYCLES_DEFAULT = 1000000;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/sr_debounce1.sv
// sr_debounce1: 2-FF synchronizer plus counter debouncer for one raw input
module sr_debounce1
  import sr_input_cond_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  localparam int CW = $clog2(DB_CYCLES)
) (
  input  logic CLK,
  input  logic R,
  input  logic RAW,
  output logic LEVEL
);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic stable;
  logic synced;
  assign synced = sync[SYNC_STAGES-1];
  assign LEVEL = stable;
  // any reversion to the stable level restarts the count from zero
  always_ff @(posedge CLK) begin
    if (R) begin
      sync <= '0;
      cnt <= '0;
      stable <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], RAW};
      if (synced == stable) cnt <= '0;
      else if (cnt == CW'(DB_CYCLES - 1)) begin
        stable <= synced;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/sr_input_cond.sv
// sr_input_cond: debounced data/enable levels and press-toggled run latch
module sr_input_cond
  import sr_input_cond_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic R,
  input  logic BTN_RAW,
  input  logic SW_RAW,
  output logic SLI,
  output logic CE,
  output logic PRESS,
  output logic BTN_DB
);
  logic btn_prev;
  logic run;
  sr_debounce1 #(.DB_CYCLES(DB_CYCLES)) u_sw (.CLK(CLK), .R(R), .RAW(SW_RAW), .LEVEL(SLI));
  sr_debounce1 #(.DB_CYCLES(DB_CYCLES)) u_btn (.CLK(CLK), .R(R), .RAW(BTN_RAW), .LEVEL(BTN_DB));
  assign CE = run;
  // CE stays a held level; the shift register samples it on its own slow tick
  always_ff @(posedge CLK) begin
    if (R) begin
      btn_prev <= 1'b0;
      PRESS <= 1'b0;
      run <= 1'b0;
    end else begin
      btn_prev <= BTN_DB;
      PRESS <= BTN_DB & ~btn_prev;
      if (PRESS) run <= ~run;
    end
  end
endmodule

// File: tb/tb_sr_input_cond.sv
// tb_sr_input_cond: directed plus random checks against a window-based debounce model
module tb_sr_input_cond;
  localparam int DB = 4;
  logic CLK = 1'b0;
  logic R = 1'b1, BTN_RAW = 1'b1, SW_RAW = 1'b1;
  logic SLI, CE, PRESS, BTN_DB;
  int ncmp = 0, nbad = 0, npulse = 0;
  bit chk_en = 1'b0;

  sr_input_cond #(.DB_CYCLES(DB)) dut (
    .CLK(CLK), .R(R), .BTN_RAW(BTN_RAW), .SW_RAW(SW_RAW),
    .SLI(SLI), .CE(CE), .PRESS(PRESS), .BTN_DB(BTN_DB)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic act, input logic exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // model: a new level is taken once the last DB synced samples since reset all agree and differ
  bit raw_q[2][$];
  bit syn_q[2][$];
  bit m_st[2];
  bit m_bold, m_press;
  int npress;
  always @(posedge CLK) begin
    bit raw[2];
    bit syn, same;
    raw[0] = SW_RAW;
    raw[1] = BTN_RAW;
    if (R) begin
      for (int i = 0; i < 2; i++) begin
        raw_q[i].delete();
        raw_q[i].push_back(1'b0);
        raw_q[i].push_back(1'b0);
        syn_q[i].delete();
        m_st[i] = 1'b0;
      end
      m_bold = 1'b0;
      m_press = 1'b0;
      npress = 0;
    end else begin
      npress += int'(m_press);
      m_press = m_st[1] & ~m_bold;
      m_bold = m_st[1];
      for (int i = 0; i < 2; i++) begin
        syn = raw_q[i][0];
        syn_q[i].push_back(syn);
        if (syn_q[i].size() > DB) void'(syn_q[i].pop_front());
        same = 1'b1;
        foreach (syn_q[i][j]) if (syn_q[i][j] != syn) same = 1'b0;
        if (syn_q[i].size() == DB && same && syn != m_st[i]) m_st[i] = syn;
        void'(raw_q[i].pop_front());
        raw_q[i].push_back(raw[i]);
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("sli", SLI, m_st[0]);
      chk("btn_db", BTN_DB, m_st[1]);
      chk("press", PRESS, m_press);
      chk("ce", CE, npress[0]);
      if (PRESS === 1'b1) npulse++;
    end
  end

  initial begin
    // reset with both raw inputs held high
    cyc(1);
    chk_en = 1'b1;
    chk("rst_sli", SLI, 1'b0);
    chk("rst_ce", CE, 1'b0);
    chk("rst_press", PRESS, 1'b0);
    chk("rst_btn_db", BTN_DB, 1'b0);
    cyc(2);
    R = 1'b0;
    cyc(5);
    chk("held_sli_e5", SLI, 1'b0);
    cyc(1);
    chk("held_sli_e6", SLI, 1'b1);
    chk("held_btn_e6", BTN_DB, 1'b1);
    cyc(1);
    chk("held_press_e7", PRESS, 1'b1);
    chk("held_ce_e7", CE, 1'b0);
    cyc(1);
    chk("held_press_e8", PRESS, 1'b0);
    chk("held_ce_e8", CE, 1'b1);
    BTN_RAW = 1'b0;
    cyc(10);
    // clean switch edges
    SW_RAW = 1'b0;
    cyc(5);
    chk("fall_e5", SLI, 1'b1);
    cyc(1);
    chk("fall_e6", SLI, 1'b0);
    SW_RAW = 1'b1;
    cyc(5);
    chk("rise_e5", SLI, 1'b0);
    cyc(1);
    chk("rise_e6", SLI, 1'b1);
    SW_RAW = 1'b0;
    cyc(8);
    // bounce shorter than the window
    for (int k = 0; k < 4; k++) begin
      SW_RAW = (k % 2 == 0);
      cyc(2);
    end
    SW_RAW = 1'b0;
    cyc(10);
    chk("bounce_sli", SLI, 1'b0);
    // single-cycle glitch while counting
    SW_RAW = 1'b1;
    cyc(2);
    SW_RAW = 1'b0;
    cyc(1);
    SW_RAW = 1'b1;
    cyc(5);
    chk("glitch_e8", SLI, 1'b0);
    cyc(1);
    chk("glitch_e9", SLI, 1'b1);
    SW_RAW = 1'b0;
    cyc(8);
    // three presses from a fresh reset
    R = 1'b1;
    cyc(1);
    R = 1'b0;
    chk("tog_ce0", CE, 1'b0);
    npulse = 0;
    for (int k = 0; k < 3; k++) begin
      BTN_RAW = 1'b1;
      cyc(10);
      chk($sformatf("tog_ce%0d", k + 1), CE, (k % 2 == 0));
      BTN_RAW = 1'b0;
      cyc(10);
    end
    chk("tog_pulses3", npulse == 3, 1'b1);
    chk("tog_ce_end", CE, 1'b1);
    // reset lands on the acceptance edge and wins
    SW_RAW = 1'b1;
    cyc(5);
    R = 1'b1;
    cyc(1);
    R = 1'b0;
    chk("midrst_sli", SLI, 1'b0);
    cyc(5);
    chk("midrst_e5", SLI, 1'b0);
    cyc(1);
    chk("midrst_e6", SLI, 1'b1);
    // random traffic against the model
    for (int t = 0; t < 3000;) begin
      int n;
      if ($urandom_range(0, 99) == 0) begin
        R = 1'b1;
        n = $urandom_range(1, 2);
      end else begin
        R = 1'b0;
        SW_RAW = 1'($urandom);
        BTN_RAW = 1'($urandom);
        n = $urandom_range(1, 12);
      end
      cyc(n);
      t += n;
    end
    R = 1'b0;
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule

// File: doc/sr_input_cond.md
Name: sr_input_cond

Overview:
- Front-end conditioner directly upstream of the 4-bit shift register on the lab board.
- Converts a raw slide switch (serial data) and a raw pushbutton (run/stop) into clean levels: SLI (data bit) and CE (shift enable).
- Each raw input passes through a 2-FF synchronizer and a counter-based debouncer.
- The debounced button toggles a run latch that drives CE as a level. The shift register samples CE only on its slow internal tick, so CE must be a held level, not a pulse.

Parameters:
- DB_CYCLES, 1000000, consecutive stable cycles required to accept a new input level (10 ms at 100 MHz); legal range >= 2.
- CW, $clog2(DB_CYCLES), debounce counter width (derived; not overridden).

Ports:
- CLK  in  1  system clock, single domain
- R  in  1  synchronous, active-high reset
- BTN_RAW  in  1  raw pushbutton, asynchronous, bouncy; 1 = pressed
- SW_RAW  in  1  raw slide switch, asynchronous, bouncy; serial data source
- SLI  out  1  debounced switch level, to shift register SLI
- CE  out  1  run latch level, to shift register CE
- PRESS  out  1  one-cycle pulse on each accepted button press
- BTN_DB  out  1  debounced button level, for LED/debug

Behaviour:
- Reset is synchronous on CLK when R=1. It clears:
  - both synchronizer chains;
  - both debounce counters;
  - the stable button and switch levels;
  - the run latch and the PRESS register.
- Outputs while R=1 and on the first cycle after: SLI=0, CE=0, PRESS=0, BTN_DB=0.
- R has priority over every other event.
- Synchronizer: 2 flops per input, reset to 0. The synced value reflects a raw level 2 CLK edges after it is applied.
- Debouncer (one per input) keeps a stable bit and a counter cnt:
  - If synced == stable: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: stable <= synced, cnt <= 0.
  - Else: cnt <= cnt+1.
- Debounce timing:
  - A clean input change appears on stable exactly 2+DB_CYCLES CLK edges after the raw edge.
  - Any reversion of synced before acceptance clears cnt. Bounce shorter than DB_CYCLES cycles never changes stable.
  - cnt never exceeds DB_CYCLES-1; no wrap.
- SLI = stable switch level (registered, no extra latency).
- BTN_DB = stable button level.
- Press detection:
  - PRESS is registered: it is 1 for exactly the single cycle after the button stable bit goes 0->1.
  - Release (1->0) produces no pulse.
- Run latch: on each PRESS cycle, run <= ~run. CE = run.
  - Press #1 sets CE=1, press #2 clears it, and so on.
- Simultaneous events:
  - Switch and button debouncers are fully independent; simultaneous acceptance is allowed.
  - R asserted in the same cycle as acceptance or PRESS: reset wins, with no toggle.
- Reset mid-debounce: the partial count is discarded. After R falls, a held raw level needs the full 2+DB_CYCLES again. Held levels are re-accepted normally: a button held through reset yields one PRESS after release of R + latency, setting CE=1.

Decomposition:
- Shared package holds only DB_CYCLES_DEFAULT (1000000) and SYNC_STAGES (2).
- Natural sub-module: sr_debounce1 (synchronizer + counter + stable bit; ports CLK, R, RAW, LEVEL). Instantiate it twice.
- The top holds the edge detector, PRESS register and run latch.

Test Plan (DB_CYCLES=4 overridden):
- Reset: hold R=1 for 3 cycles with BTN_RAW=1, SW_RAW=1 -> SLI=CE=PRESS=BTN_DB=0 during R. After R falls, SLI=1 at edge 6 (2+4), and PRESS pulses once with CE=1.
- Clean switch: SW_RAW 0->1 held -> SLI rises exactly 6 edges later. Then 1->0 -> SLI falls 6 edges later.
- Bounce: SW_RAW toggles 1,0,1,0 with each level held 2 cycles, then stays 0 -> SLI never leaves 0.
- Glitch: start a clean 1 on SW_RAW, then a 1-cycle 0 glitch at synced cnt=2 -> cnt restarts, and SLI rises 4 edges after the glitch clears from the synchronizer.
- Toggle: three clean button presses, each held 10 cycles -> exactly three 1-cycle PRESS pulses, each on press acceptance, none on release. CE sequence 1,0,1.
- Reset mid-count: SW_RAW=1 held, assert R for 1 cycle when cnt=3 -> SLI stays 0, then rises 6 edges after R deasserts.
